io_input_bank: RTL and testbench

- Parametrised, memory-mapped input-port block for the pipelined computer; generalises the two fixed 4-bit input ports to CHANNELS ports of WIDTH bits each.
- Each channel passes through a 2-flop synchroniser and a stability counter (debounce) into a debounced register.
- A change flag is set when a channel's debounced value changes. The CPU reads each channel on the data-memory read path, one cycle after the request.

---
 rtl/io_pkg.sv | 32 +++
 rtl/io_debounce_chan.sv | 58 +++++
 rtl/io_input_bank.sv | 103 ++++++++++
 tb/tb_io_input_bank.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped input bank: address offsets, region decode and
// the counter-width helper.
package io_pkg;

  // First channel data word; the pending and mask words follow the last channel word.
  localparam int unsigned IO_DATA_BASE = 0;
  localparam int unsigned IO_PEND_OFS  = 0;
  localparam int unsigned IO_MASK_OFS  = 1;

  typedef enum logic [1:0] {
    RegData,
    RegPend,
    RegMask,
    RegNone
  } io_region_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  function automatic io_region_e io_decode(input logic [31:0] word_addr,
                                           input int unsigned channels);
    if (word_addr < IO_DATA_BASE + channels) return RegData;
    if (word_addr == IO_DATA_BASE + channels + IO_PEND_OFS) return RegPend;
    if (word_addr == IO_DATA_BASE + channels + IO_MASK_OFS) return RegMask;
    return RegNone;
  endfunction

endpackage

// File: rtl/io_debounce_chan.sv
// One input channel: 2-flop synchroniser, previous-sample register and stability counter
// feeding the debounced value. changed_o pulses in the cycle the new value is accepted.
module io_debounce_chan
  import io_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] deb_o,
  output logic             changed_o
);

  localparam int unsigned CntW = clog2(DEBOUNCE_CYCLES) + 1;

  logic [WIDTH-1:0] s1_q, s2_q, sp_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    accept = 1'b0;
    // Any disagreement with the previous sample restarts the stability window.
    if ((s2_q == deb_q) || (s2_q != sp_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
      accept = 1'b1;
      deb_d  = s2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= '0;
      s2_q  <= '0;
      sp_q  <= '0;
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= in_i;
      s2_q  <= s1_q;
      sp_q  <= s2_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o     = deb_q;
  assign changed_o = accept;

endmodule

// File: rtl/io_input_bank.sv
// Memory-mapped bank of debounced input channels with read-to-clear change flags.
// Define IO_IRQ_EN to add the interrupt mask word and a registered irq output.
module io_input_bank
  import io_pkg::*;
#(
  parameter int unsigned CHANNELS        = 2,
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ADDR_W          = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_port,
  input  logic                      rd,
  input  logic                      wr,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata,
  output logic [CHANNELS-1:0]       pending,
  output logic                      irq
);

  logic [WIDTH-1:0]    deb [CHANNELS];
  logic [CHANNELS-1:0] changed;
  logic [CHANNELS-1:0] pending_q, pending_d, clr;
  logic [31:0]         rdata_q, rdata_d, rd_mux, mask_rd, addr_ext;
  io_region_e          region;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    io_debounce_chan #(
      .WIDTH          (WIDTH),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i    (clock),
      .rst_i    (reset),
      .in_i     (in_port[g*WIDTH +: WIDTH]),
      .deb_o    (deb[g]),
      .changed_o(changed[g])
    );
  end

  assign addr_ext = 32'(addr);
  assign region   = io_decode(addr_ext, CHANNELS);

  always_comb begin
    rd_mux = '0;
    clr    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (addr_ext == 32'(IO_DATA_BASE + i)) begin
        rd_mux = 32'(deb[i]);
        clr[i] = rd;
      end
    end
    case (region)
      RegPend: rd_mux = 32'(pending_q);
      RegMask: rd_mux = mask_rd;
      default: ;
    endcase
    // A flag set in the same cycle as its read-clear survives.
    pending_d = (pending_q & ~clr) | changed;
    rdata_d   = rd ? rd_mux : rdata_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      rdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef IO_IRQ_EN
  logic [CHANNELS-1:0] mask_q;
  logic                irq_q;
  logic                unused_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr && (region == RegMask)) mask_q <= wdata[CHANNELS-1:0];
      irq_q <= |(pending_q & mask_q);
    end
  end

  assign mask_rd      = 32'(mask_q);
  assign irq          = irq_q;
  assign unused_wdata = ^wdata[31:CHANNELS];
`else
  logic unused_wr;

  assign mask_rd   = '0;
  assign irq       = 1'b0;
  assign unused_wr = ^{wr, wdata};
`endif

  assign rdata   = rdata_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_io_input_bank.sv
// Directed bench for io_input_bank (default parameters); read data checked via a scoreboard.
module tb_io_input_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_port = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [1:0]  pending;
  logic        irq;

  int          total = 0;
  int          bad = 0;
  logic [31:0] expq[$];

  io_input_bank #(
    .CHANNELS       (2),
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .ADDR_W         (5)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .in_port(in_port),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .pending(pending),
    .irq    (irq)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] e;
    rd   = 1'b1;
    addr = a;
    expq.push_back(exp);
    tick();
    rd = 1'b0;
    if (expq.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = expq.pop_front();
      check($sformatf("rd_addr%0d", a), rdata, e);
    end
  endtask

  task automatic check_irq(input string tag, input logic exp_on);
`ifdef IO_IRQ_EN
    check(tag, 32'(irq), 32'(exp_on));
`else
    check(tag, 32'(irq), 32'd0);
`endif
  endtask

  initial begin
    ticks(2);
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    ticks(5);

    // Clean step on channel 0: accepted exactly 7 edges later.
    in_port = 8'h0F;
    ticks(6);
    check("ch0_step_early", 32'(pending), 32'd0);
    tick();
    check("ch0_step_pending", 32'(pending), 32'd1);
    do_read(5'd0, 32'h0000_000F);
    check("ch0_read_clears", 32'(pending), 32'd0);
    tick();
    check("rdata_holds", rdata, 32'h0000_000F);

    // Three-cycle glitch on channel 1 is rejected.
    in_port = 8'hDF;
    ticks(3);
    in_port = 8'h0F;
    ticks(10);
    check("glitch_pending", 32'(pending), 32'd0);
    do_read(5'd1, 32'd0);
    in_port = 8'hDF;
    ticks(10);
    check("ch1_hold_pending", 32'(pending), 32'd2);

    in_port = 8'hD5;
    ticks(7);
    check("both_pending", 32'(pending), 32'd3);
    do_read(5'd2, 32'd3);
    check("pend_word_no_clear", 32'(pending), 32'd3);
    do_read(5'd7, 32'd0);
    do_read(5'd3, 32'd0);

    // Channel 0 accepts a new value on the same edge its data word is read.
    in_port = 8'hDA;
    ticks(6);
    do_read(5'd0, 32'h0000_0005);
    check("set_wins_pending", 32'(pending), 32'd3);
    do_read(5'd0, 32'h0000_000A);
    check("after_second_read", 32'(pending), 32'd2);
    do_read(5'd1, 32'h0000_000D);
    check("all_clear", 32'(pending), 32'd0);

    // Reset while channel 0 is mid-count.
    in_port = 8'hD3;
    ticks(5);
    reset = 1'b1;
    #1;
    check("async_rst_pending", 32'(pending), 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
    tick();
    reset = 1'b0;
    ticks(6);
    check("post_rst_early", 32'(pending), 32'd0);
    tick();
    check("post_rst_pending", 32'(pending), 32'd3);
    do_read(5'd0, 32'h0000_0003);
    do_read(5'd1, 32'h0000_000D);
    check("post_rst_clear", 32'(pending), 32'd0);

    // Mask channel 1 only; a stray write elsewhere must be ignored.
    wr = 1'b1; addr = 5'd3; wdata = 32'h2;
    tick();
    addr = 5'd0; wdata = 32'hFFFF_FFFF;
    tick();
    wr = 1'b0;
`ifdef IO_IRQ_EN
    do_read(5'd3, 32'h2);
`else
    do_read(5'd3, 32'h0);
`endif
    in_port = 8'hD7;
    ticks(8);
    check("ch0_only_pending", 32'(pending), 32'd1);
    check_irq("ch0_no_irq", 1'b0);
    do_read(5'd0, 32'h0000_0007);
    in_port = 8'h17;
    ticks(7);
    check("ch1_pending", 32'(pending), 32'd2);
    check_irq("irq_not_yet", 1'b0);
    tick();
    check_irq("irq_set", 1'b1);
    do_read(5'd1, 32'h0000_0001);
    check_irq("irq_still_on", 1'b1);
    tick();
    check_irq("irq_dropped", 1'b0);

    check("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
